// File: rtl/wb_xbar_pkg.sv
// wb_xbar_pkg: shared region constants, selector/owner enums and bus bundles for the crossbar.
package wb_xbar_pkg;
    localparam logic [31:0] ROM_BASE_DEF  = 32'h0000_0000;
    localparam logic [31:0] UART_BASE_DEF = 32'h1000_0000;
    localparam logic [31:0] RAM_BASE_DEF  = 32'h8000_0000;
    localparam logic [31:0] REGION_MASK   = 32'hF000_0000;

    typedef enum logic [1:0] {SLV_ROM, SLV_RAM, SLV_UART, SLV_NONE} slave_sel_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
    } wb_rsp_t;

    // RAM owns the whole upper half, so it is checked before the 256 MB regions
    function automatic slave_sel_t decode(input logic [31:0] a, rom_b, uart_b, ram_b);
        return (a[31] == ram_b[31]) ? SLV_RAM :
               ((a & REGION_MASK) == (rom_b & REGION_MASK))  ? SLV_ROM :
               ((a & REGION_MASK) == (uart_b & REGION_MASK)) ? SLV_UART : SLV_NONE;
    endfunction
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: Wishbone classic bundle; master drives the request, slave drives data_out/ack.
interface wishbone_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        write_enable;
    logic [3:0]  select;
    logic        strobe;
    logic        cycle;
    logic        ack;

    modport master(output address, data_in, write_enable, select, strobe, cycle,
                   input data_out, ack);
    modport slave(input address, data_in, write_enable, select, strobe, cycle,
                  output data_out, ack);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-requester fixed-priority arbiter; grant is held until the owner drops cycle.
module wb_arbiter2
    import wb_xbar_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic [1:0] i_cyc,
    output owner_t     o_owner
);
    owner_t r_owner;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_owner <= OWN_NONE;
        else
            r_owner <= (r_owner == OWN_NONE) ? (i_req[0] ? OWN_M0 : i_req[1] ? OWN_M1 : OWN_NONE) :
                       ((r_owner == OWN_M0) ? i_cyc[0] : i_cyc[1]) ? r_owner : OWN_NONE;

    assign o_owner = r_owner;
endmodule

// File: rtl/wishbone_crossbar.sv
// wishbone_crossbar: 2-master x 3-slave Wishbone classic crossbar (ROM, RAM, UART)
// with per-slave arbitration and local termination of unmapped accesses.
module wishbone_crossbar
    import wb_xbar_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
    parameter logic [31:0] UART_BASE = UART_BASE_DEF,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    wishbone_if.slave  wb_m0,
    wishbone_if.slave  wb_m1,
    wishbone_if.master wb_rom,
    wishbone_if.master wb_ram,
    wishbone_if.master wb_uart
);
    wb_req_t    w_mreq[2];
    wb_rsp_t    w_mrsp[2];
    wb_req_t    w_sreq[3];
    wb_rsp_t    w_srsp[3];
    slave_sel_t w_sel[2];
    owner_t     w_own[3];
    logic [1:0] r_um_ack;

    assign w_mreq[0] = {wb_m0.address, wb_m0.data_in, wb_m0.write_enable, wb_m0.select, wb_m0.strobe, wb_m0.cycle};
    assign w_mreq[1] = {wb_m1.address, wb_m1.data_in, wb_m1.write_enable, wb_m1.select, wb_m1.strobe, wb_m1.cycle};
    assign {wb_m0.data_out, wb_m0.ack} = w_mrsp[0];
    assign {wb_m1.data_out, wb_m1.ack} = w_mrsp[1];

    assign {wb_rom.address, wb_rom.data_in, wb_rom.write_enable, wb_rom.select, wb_rom.strobe, wb_rom.cycle} = w_sreq[0];
    assign {wb_ram.address, wb_ram.data_in, wb_ram.write_enable, wb_ram.select, wb_ram.strobe, wb_ram.cycle} = w_sreq[1];
    assign {wb_uart.address, wb_uart.data_in, wb_uart.write_enable, wb_uart.select, wb_uart.strobe, wb_uart.cycle} = w_sreq[2];
    assign w_srsp[0] = {wb_rom.data_out, wb_rom.ack};
    assign w_srsp[1] = {wb_ram.data_out, wb_ram.ack};
    assign w_srsp[2] = {wb_uart.data_out, wb_uart.ack};

    assign w_sel[0] = decode(w_mreq[0].adr, ROM_BASE, UART_BASE, RAM_BASE);
    assign w_sel[1] = decode(w_mreq[1].adr, ROM_BASE, UART_BASE, RAM_BASE);

    // slave index s follows slave_sel_t ordering: 0=ROM, 1=RAM, 2=UART
    for (genvar s = 0; s < 3; s++) begin : g_slv
        logic [1:0] w_req;
        assign w_req = {w_mreq[1].cyc & w_mreq[1].stb & (w_sel[1] == slave_sel_t'(s)),
                        w_mreq[0].cyc & w_mreq[0].stb & (w_sel[0] == slave_sel_t'(s))};
        wb_arbiter2 u_arb (
            .clk     (clk),
            .reset   (reset),
            .i_req   (w_req),
            .i_cyc   ({w_mreq[1].cyc, w_mreq[0].cyc}),
            .o_owner (w_own[s])
        );
        assign w_sreq[s] = (w_own[s] == OWN_M0) ? w_mreq[0] :
                           (w_own[s] == OWN_M1) ? w_mreq[1] : '0;
    end

    // the ~r_um_ack term keeps a held strobe from producing a second ack
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_um_ack <= '0;
        else
            for (int m = 0; m < 2; m++)
                r_um_ack[m] <= w_mreq[m].cyc & w_mreq[m].stb & (w_sel[m] == SLV_NONE) & ~r_um_ack[m];

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            w_mrsp[m] = {32'h0, r_um_ack[m]};
            for (int s = 0; s < 3; s++)
                if (w_sel[m] == slave_sel_t'(s) && w_own[s] == ((m == 0) ? OWN_M0 : OWN_M1))
                    w_mrsp[m] = w_srsp[s];
        end
    end
endmodule

// File: tb/tb_wishbone_crossbar.sv
// tb_wishbone_crossbar: directed tests of the crossbar against simple ROM/RAM/UART slave models.
module tb_wishbone_crossbar;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    wishbone_if m0_if();
    wishbone_if m1_if();
    wishbone_if rom_if();
    wishbone_if ram_if();
    wishbone_if uart_if();

    logic [31:0] m_adr[2];
    logic [31:0] m_dat[2];
    logic        m_we[2];
    logic        m_cyc[2];
    logic        m_stb[2];
    logic        m_ack[2];
    logic [31:0] m_rdat[2];
    logic [31:0] ram_mem[16];

    wishbone_crossbar dut (
        .clk     (clk),
        .reset   (reset),
        .wb_m0   (m0_if),
        .wb_m1   (m1_if),
        .wb_rom  (rom_if),
        .wb_ram  (ram_if),
        .wb_uart (uart_if)
    );

    assign m0_if.address      = m_adr[0];
    assign m0_if.data_in      = m_dat[0];
    assign m0_if.write_enable = m_we[0];
    assign m0_if.select       = 4'hF;
    assign m0_if.strobe       = m_stb[0];
    assign m0_if.cycle        = m_cyc[0];
    assign m1_if.address      = m_adr[1];
    assign m1_if.data_in      = m_dat[1];
    assign m1_if.write_enable = m_we[1];
    assign m1_if.select       = 4'hF;
    assign m1_if.strobe       = m_stb[1];
    assign m1_if.cycle        = m_cyc[1];
    assign m_ack[0]  = m0_if.ack;
    assign m_ack[1]  = m1_if.ack;
    assign m_rdat[0] = m0_if.data_out;
    assign m_rdat[1] = m1_if.data_out;

    // slave models: registered single-cycle ack, combinational read data
    assign rom_if.data_out  = 32'hA5A5_0000 | {16'h0, rom_if.address[15:0]};
    assign ram_if.data_out  = ram_mem[ram_if.address[5:2]];
    assign uart_if.data_out = 32'h0000_0055;

    always @(posedge clk or negedge reset)
        if (!reset) begin
            rom_if.ack  <= 1'b0;
            uart_if.ack <= 1'b0;
            ram_if.ack  <= 1'b0;
            for (int i = 0; i < 16; i++) ram_mem[i] <= 32'h0;
        end else begin
            rom_if.ack  <= rom_if.cycle & rom_if.strobe & ~rom_if.ack;
            uart_if.ack <= uart_if.cycle & uart_if.strobe & ~uart_if.ack;
            ram_if.ack  <= ram_if.cycle & ram_if.strobe & ~ram_if.ack;
            if (ram_if.cycle & ram_if.strobe & ram_if.write_enable & ~ram_if.ack)
                ram_mem[ram_if.address[5:2]] <= ram_if.data_in;
        end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic xfer(input int m, input logic [31:0] a, input logic we, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        m_adr[m] = a;
        m_dat[m] = d;
        m_we[m]  = we;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_ack[m] && lat < 20);
        rd = m_rdat[m];
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (rom_if.strobe !== 1'b0 || ram_if.strobe !== 1'b0 || uart_if.strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_slave_stb got %b%b%b exp 000", rom_if.strobe, ram_if.strobe, uart_if.strobe);
        end
        vectors++;
        if (rom_if.cycle !== 1'b0 || ram_if.cycle !== 1'b0 || uart_if.cycle !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_slave_cyc got %b%b%b exp 000", rom_if.cycle, ram_if.cycle, uart_if.cycle);
        end
        vectors++;
        if (m_ack[0] !== 1'b0 || m_ack[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_master_ack got %b%b exp 00", m_ack[1], m_ack[0]);
        end
    endtask

    task automatic test_rom_read();
        logic [31:0] rd;
        int lat;
        int m1_acks;
        m1_acks = 0;
        fork
            xfer(0, 32'h0000_0000, 1'b0, 32'h0, rd, lat);
            repeat (4) begin
                @(negedge clk);
                if (m_ack[1]) m1_acks++;
            end
        join
        vectors++;
        if (rd !== 32'hA5A5_0000) begin
            miscompares++;
            $display("FAIL rom_data got %h exp a5a50000", rd);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL rom_latency got %0d exp 2", lat);
        end
        vectors++;
        if (m1_acks !== 0) begin
            miscompares++;
            $display("FAIL rom_m1_idle_ack got %0d exp 0", m1_acks);
        end
    endtask

    task automatic test_ram_rw();
        logic [31:0] rd;
        int lat;
        xfer(0, 32'h8000_0000, 1'b1, 32'hDEAD_BEEF, rd, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL ram_write_latency got %0d exp 2", lat);
        end
        xfer(0, 32'h8000_0000, 1'b0, 32'h0, rd, lat);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL ram_readback got %h exp deadbeef", rd);
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] rd0, rd1, rd2;
        int lat0, lat1, lat2;
        fork
            xfer(0, 32'h0000_0008, 1'b0, 32'h0, rd0, lat0);
            begin
                xfer(1, 32'h8000_0012, 1'b1, 32'hCAFE_BABE, rd1, lat1);
                xfer(1, 32'h8000_0012, 1'b0, 32'h0, rd2, lat2);
            end
        join
        vectors++;
        if (rd0 !== 32'hA5A5_0008 || lat0 !== 2) begin
            miscompares++;
            $display("FAIL conc_m0_rom got %h/%0d exp a5a50008/2", rd0, lat0);
        end
        vectors++;
        if (lat1 !== 2) begin
            miscompares++;
            $display("FAIL conc_m1_write_latency got %0d exp 2", lat1);
        end
        vectors++;
        if (rd2 !== 32'hCAFE_BABE) begin
            miscompares++;
            $display("FAIL conc_m1_readback got %h exp cafebabe", rd2);
        end
    endtask

    task automatic test_contention();
        logic [31:0] rd0, rd1;
        int lat0, lat1;
        fork
            xfer(0, 32'h8000_0000, 1'b0, 32'h0, rd0, lat0);
            xfer(1, 32'h8000_0010, 1'b0, 32'h0, rd1, lat1);
        join
        vectors++;
        if (lat0 !== 2 || rd0 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL contend_m0 got %0d/%h exp 2/deadbeef", lat0, rd0);
        end
        vectors++;
        if (lat1 !== 5 || rd1 !== 32'hCAFE_BABE) begin
            miscompares++;
            $display("FAIL contend_m1 got %0d/%h exp 5/cafebabe", lat1, rd1);
        end
    endtask

    task automatic test_no_preempt();
        int lat;
        int acks;
        @(negedge clk);
        m_adr[1] = 32'h8000_0008;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_ack[1] && lat < 20);
        m_stb[1] = 1'b0;
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL hold_m1_latency got %0d exp 2", lat);
        end
        m_adr[0] = 32'h8000_0000;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack[0]) acks++;
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++;
            $display("FAIL hold_m0_stalled got %0d acks exp 0", acks);
        end
        m_cyc[1] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_ack[0] && lat < 20);
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL hold_m0_after_release got %0d exp 3", lat);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        int lat;
        @(negedge clk);
        m_adr[0] = 32'h4000_0000;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_ack[0] !== 1'b1 || m_rdat[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_ack got %b/%h exp 1/00000000", m_ack[0], m_rdat[0]);
        end
        @(negedge clk);
        vectors++;
        if (m_ack[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL unmapped_single_ack got %b exp 0", m_ack[0]);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        xfer(1, 32'h4000_0010, 1'b1, 32'h1234_5678, rd, lat);
        vectors++;
        if (lat !== 1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_m1_write got %0d/%h exp 1/00000000", lat, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        @(negedge clk);
        m_adr[0] = 32'h8000_0000;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if (ram_if.strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_granted got %b exp 1", ram_if.strobe);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (ram_if.strobe !== 1'b0 || ram_if.cycle !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_slave got stb %b cyc %b exp 0 0", ram_if.strobe, ram_if.cycle);
        end
        vectors++;
        if (m_ack[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_m0_ack got %b exp 0", m_ack[0]);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        xfer(1, 32'h8000_0004, 1'b0, 32'h0, rd, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL midrst_free_after got %0d exp 2", lat);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = 32'h0;
            m_dat[i] = 32'h0;
            m_we[i]  = 1'b0;
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_rom_read();
        test_ram_rw();
        test_concurrent();
        test_contention();
        test_no_preempt();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
